// File: rtl/fft_reorder_pkg.sv
// Shared constants and helpers for the 8-point FFT output reorder buffer.
package fft_reorder_pkg;

  localparam int N_POINTS    = 8;
  localparam int LOG2N       = 3;
  localparam int NB_DATA_DEF = 12;
  localparam int NB_AXIS_DEF = 2 * NB_DATA_DEF;

  function automatic logic [LOG2N-1:0] bitrev3(
    input logic [LOG2N-1:0] a
  );
    return {a[0], a[1], a[2]};
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// 8-entry register file: one write port, one combinational read port.
module fft_reorder_bank
  import fft_reorder_pkg::*;
#(
  parameter int W = NB_AXIS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [LOG2N-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [LOG2N-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [N_POINTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_POINTS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_mdc_out_reorder.sv
// Ping-pong bit-reversed to natural-order AXIS reorder buffer.
// Optional tlast framing check: FFT_REORDER_TLAST_CHECK_EN.
module fft_mdc_out_reorder
  import fft_reorder_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 s_axis_data_tvalid,
  input  logic [2*NB_DATA-1:0] s_axis_data_tdata,
  input  logic                 s_axis_data_tlast,
  output logic                 s_axis_data_tready,
  output logic                 m_axis_data_tvalid,
  output logic [2*NB_DATA-1:0] m_axis_data_tdata,
  output logic                 m_axis_data_tlast,
  input  logic                 m_axis_data_tready,
  output logic                 o_frame_err
);

  localparam int NB_BEAT = 2 * NB_DATA;

  logic             r_run;
  logic             wr_bank;
  logic [LOG2N-1:0] wr_cnt;
  logic             rd_bank;
  logic [LOG2N-1:0] rd_cnt;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             s_acc;
  logic             m_acc;
  logic             wr_last;
  logic             rd_last;
  logic             abort;
  logic [NB_BEAT-1:0] rdata [2];

  assign s_axis_data_tready = r_run & ~full[wr_bank];
  assign s_acc   = s_axis_data_tvalid & s_axis_data_tready;
  assign m_acc   = m_axis_data_tvalid & m_axis_data_tready;
  assign wr_last = (wr_cnt == LOG2N'(N_POINTS - 1));
  assign rd_last = (rd_cnt == LOG2N'(N_POINTS - 1));

`ifdef FFT_REORDER_TLAST_CHECK_EN
  logic err_q;

  assign abort = s_acc & s_axis_data_tlast & ~wr_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= abort | (s_acc & wr_last & ~s_axis_data_tlast);
    end
  end

  assign o_frame_err = err_q;
`else
  logic unused_tlast;

  assign unused_tlast = s_axis_data_tlast;
  assign abort        = 1'b0;
  assign o_frame_err  = 1'b0;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(
      .W(NB_BEAT)
    ) u_bank (
      .clk  (i_clk),
      .rst_n(i_rst_n),
      .we   (s_acc & (wr_bank == 1'(b))),
      .waddr(bitrev3(wr_cnt)),
      .wdata(s_axis_data_tdata),
      .raddr(rd_cnt),
      .rdata(rdata[b])
    );
  end

  // Set and clear never hit the same bank, so order does not matter.
  always_comb begin
    full_nxt = full;
    if (m_acc && rd_last) begin
      full_nxt[rd_bank] = 1'b0;
    end
    if (s_acc && wr_last && !abort) begin
      full_nxt[wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run   <= 1'b0;
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
      full    <= '0;
    end else begin
      r_run <= 1'b1;
      full  <= full_nxt;
      if (s_acc) begin
        if (abort) begin
          wr_cnt <= '0;
        end else if (wr_last) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (m_acc) begin
        if (rd_last) begin
          rd_cnt  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  assign m_axis_data_tvalid = full[rd_bank];
  assign m_axis_data_tdata  = rdata[rd_bank];
  assign m_axis_data_tlast  = m_axis_data_tvalid & rd_last;

endmodule
